// File: rtl/tff_toggle_conditioner_if.sv
// ----------------------------------------------------------------------------
// tff_toggle_conditioner_if
//   Bundles the button input and the conditioned outputs of the toggle
//   conditioner so that the producer (pin/bench) and the conditioner share
//   one connection.
//   Signals:
//     btn_raw       raw asynchronous button/pin level, active-high
//     toggle_pulse  one-cycle pulse per accepted press/repeat (T input)
//     btn_level     debounced button level
//     busy          conditioner FSM not idle
//     press_count   wrapping count of toggle_pulse events
//   Modports:
//     master  drives btn_raw, observes the outputs
//     slave   the conditioner side
// ----------------------------------------------------------------------------
interface tff_toggle_conditioner_if;
  logic       btn_raw;
  logic       toggle_pulse;
  logic       btn_level;
  logic       busy;
  logic [7:0] press_count;

  modport master (
    output btn_raw,
    input  toggle_pulse,
    input  btn_level,
    input  busy,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output toggle_pulse,
    output btn_level,
    output busy,
    output press_count
  );
endinterface

// File: rtl/tff_toggle_conditioner.sv
// ----------------------------------------------------------------------------
// tff_toggle_conditioner
//   Synchronises and debounces a bouncy button, emitting a single registered
//   toggle_pulse per accepted press (plus optional auto-repeat while held).
//   Ports:
//     clk      clock
//     rst_n    asynchronous active-low reset
//     bus      tff_toggle_conditioner_if.slave
//                btn_raw (in), toggle_pulse, btn_level, busy, press_count (out)
//   Parameters:
//     SYNC_STAGES      synchroniser depth (>=2)
//     DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>=2)
//     REPEAT_EN        1 enables auto-repeat while held
//     REPEAT_DELAY     cycles from press pulse to first repeat (>=1)
//     REPEAT_PERIOD    cycles between repeats (>=1)
// ----------------------------------------------------------------------------
module tff_toggle_conditioner #(
  parameter int unsigned SYNC_STAGES     = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd16,
  parameter int unsigned REPEAT_EN       = 32'd0,
  parameter int unsigned REPEAT_DELAY    = 32'd64,
  parameter int unsigned REPEAT_PERIOD   = 32'd16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tff_toggle_conditioner_if.slave bus
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W = $clog2(RMAX + 32'd1);

  localparam logic [DCNT_W-1:0] DCNT_TERM  = DCNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(32'd1);
  localparam logic [DCNT_W-1:0] DCNT_ZERO  = DCNT_W'(32'd0);
  localparam logic [RCNT_W-1:0] RDLY_TERM  = RCNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [RCNT_W-1:0] RPER_TERM  = RCNT_W'(REPEAT_PERIOD - 32'd1);
  localparam logic [RCNT_W-1:0] RCNT_ONE   = RCNT_W'(32'd1);
  localparam logic [RCNT_W-1:0] RCNT_ZERO  = RCNT_W'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [DCNT_W-1:0]      r_dcnt;
  logic [RCNT_W-1:0]      r_rcnt;
  logic                   r_rphase;       // 0: waiting REPEAT_DELAY, 1: REPEAT_PERIOD
  logic                   r_toggle_pulse;
  logic                   r_btn_level;
  logic                   r_busy;
  logic [7:0]             r_press_count;

  logic                   w_s;
  state_t                 w_state_nxt;
  logic [DCNT_W-1:0]      w_dcnt_nxt;
  logic [RCNT_W-1:0]      w_rcnt_nxt;
  logic                   w_rphase_nxt;
  logic                   w_pulse_nxt;
  logic                   w_level_nxt;
  logic                   w_busy_nxt;
  logic                   w_rep_hit;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Repeat timer terminal count for whichever phase (delay or period) is active.
  assign w_rep_hit = r_rphase ? (r_rcnt == RPER_TERM) : (r_rcnt == RDLY_TERM);

  // Synchroniser chain bringing btn_raw into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_raw};
    end
  end

  // Next-state, counter and output decode for the debounce/repeat FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_rcnt_nxt   = r_rcnt;
    w_rphase_nxt = r_rphase;
    w_pulse_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dcnt_nxt   = DCNT_ZERO;
        w_rcnt_nxt   = RCNT_ZERO;
        w_rphase_nxt = 1'b0;
        if (w_s) begin
          w_state_nxt = ST_PRESS_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = DCNT_ZERO;
        end else if (r_dcnt == DCNT_TERM) begin
          // Accepted press: pulse and restart the repeat timer in its delay phase.
          w_state_nxt  = ST_HELD;
          w_dcnt_nxt   = DCNT_ZERO;
          w_rcnt_nxt   = RCNT_ZERO;
          w_rphase_nxt = 1'b0;
          w_pulse_nxt  = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_ONE;
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_nxt  = ST_RELEASE_WAIT;
          w_dcnt_nxt   = DCNT_ZERO;
          w_rcnt_nxt   = RCNT_ZERO;
          w_rphase_nxt = 1'b0;
        end else if (REPEAT_EN != 32'd0) begin
          if (w_rep_hit) begin
            w_pulse_nxt  = 1'b1;
            w_rcnt_nxt   = RCNT_ZERO;
            w_rphase_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + RCNT_ONE;
          end
        end else begin
          w_rcnt_nxt   = RCNT_ZERO;
          w_rphase_nxt = 1'b0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_s) begin
          // Release bounce: back to HELD, repeat delay starts over, no pulse.
          w_state_nxt  = ST_HELD;
          w_dcnt_nxt   = DCNT_ZERO;
          w_rcnt_nxt   = RCNT_ZERO;
          w_rphase_nxt = 1'b0;
        end else if (r_dcnt == DCNT_TERM) begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = DCNT_ZERO;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_ONE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_dcnt_nxt   = DCNT_ZERO;
        w_rcnt_nxt   = RCNT_ZERO;
        w_rphase_nxt = 1'b0;
      end
    endcase
    // Level and busy are registered from the next state so they track it exactly.
    w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_WAIT);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_dcnt         <= DCNT_ZERO;
      r_rcnt         <= RCNT_ZERO;
      r_rphase       <= 1'b0;
      r_toggle_pulse <= 1'b0;
      r_btn_level    <= 1'b0;
      r_busy         <= 1'b0;
      r_press_count  <= 8'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_dcnt         <= w_dcnt_nxt;
      r_rcnt         <= w_rcnt_nxt;
      r_rphase       <= w_rphase_nxt;
      r_toggle_pulse <= w_pulse_nxt;
      r_btn_level    <= w_level_nxt;
      r_busy         <= w_busy_nxt;
      if (w_pulse_nxt) begin
        r_press_count <= r_press_count + 8'd1;
      end else begin
        r_press_count <= r_press_count;
      end
    end
  end

  assign bus.toggle_pulse = r_toggle_pulse;
  assign bus.btn_level    = r_btn_level;
  assign bus.busy         = r_busy;
  assign bus.press_count  = r_press_count;

endmodule

// File: tb/tb_tff_toggle_conditioner.sv
// ----------------------------------------------------------------------------
// tb_tff_toggle_conditioner
//   Drives two conditioners (repeat off / repeat on) from the same button
//   stimulus and compares every cycle against a run-length reference model:
//   a level change is accepted once the synchronised input has disagreed
//   with the debounced level on DEBOUNCE_CYCLES+1 consecutive edges; repeats
//   fall at fixed offsets from the last time the hold (re)started.
// ----------------------------------------------------------------------------
module tb_tff_toggle_conditioner;
  localparam int SYNC   = 2;
  localparam int DEB    = 16;
  localparam int DELAY  = 64;
  localparam int PERIOD = 16;

  logic clk;
  logic rst_n;
  logic btn_raw;

  tff_toggle_conditioner_if if0 ();
  tff_toggle_conditioner_if if1 ();

  assign if0.btn_raw = btn_raw;
  assign if1.btn_raw = btn_raw;

  tff_toggle_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  tff_toggle_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state, index 0 = repeat off, 1 = repeat on
  bit     mq[$];
  bit     mlvl[2];
  int     mrun[2];
  longint manc[2];
  bit     mp[2];
  bit     mbusy[2];
  bit [7:0] mcnt[2];
  longint tick;

  int  edge_idx;
  int  pe0[$];
  int  pe1[$];
  int  fall0;
  bit  prev_lvl0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < SYNC; k++) mq.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      mlvl[i] = 1'b0; mrun[i] = 0; manc[i] = 0;
      mp[i] = 1'b0; mbusy[i] = 1'b0; mcnt[i] = 8'd0;
    end
  endtask

  task automatic model_step(input bit raw);
    bit s;
    longint d;
    s = mq.pop_front();
    mq.push_back(raw);
    tick++;
    for (int i = 0; i < 2; i++) begin
      mp[i] = 1'b0;
      if (s != mlvl[i]) begin
        mrun[i]++;
        if (mrun[i] == DEB + 1) begin
          mlvl[i] = s;
          mrun[i] = 0;
          if (s) begin
            mp[i] = 1'b1;
            manc[i] = tick;
          end
        end
      end else begin
        if (mlvl[i] && mrun[i] > 0) manc[i] = tick;   // hold restarted after a release bounce
        mrun[i] = 0;
        if (mlvl[i] && i == 1) begin
          d = tick - manc[i];
          if (d >= DELAY && ((d - DELAY) % PERIOD) == 0) mp[i] = 1'b1;
        end
      end
      mcnt[i] = mcnt[i] + {7'd0, mp[i]};
      mbusy[i] = mlvl[i] || (mrun[i] > 0);
    end
  endtask

  task automatic check_outputs();
    check_val("pulse0", {31'd0, if0.toggle_pulse}, {31'd0, mp[0]});
    check_val("level0", {31'd0, if0.btn_level},    {31'd0, mlvl[0]});
    check_val("busy0",  {31'd0, if0.busy},         {31'd0, mbusy[0]});
    check_val("count0", {24'd0, if0.press_count},  {24'd0, mcnt[0]});
    check_val("pulse1", {31'd0, if1.toggle_pulse}, {31'd0, mp[1]});
    check_val("level1", {31'd0, if1.btn_level},    {31'd0, mlvl[1]});
    check_val("busy1",  {31'd0, if1.busy},         {31'd0, mbusy[1]});
    check_val("count1", {24'd0, if1.press_count},  {24'd0, mcnt[1]});
  endtask

  // one clock: drive at negedge, step model at posedge, check 1ns later
  task automatic cyc(input bit raw);
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    if (rst_n) model_step(raw);
    else model_reset();
    #1;
    check_outputs();
    if (if0.toggle_pulse === 1'b1) pe0.push_back(edge_idx);
    if (if1.toggle_pulse === 1'b1) pe1.push_back(edge_idx);
    if (prev_lvl0 && if0.btn_level === 1'b0) fall0 = edge_idx;
    prev_lvl0 = (if0.btn_level === 1'b1);
    edge_idx++;
  endtask

  task automatic run(input bit raw, input int n);
    for (int k = 0; k < n; k++) cyc(raw);
  endtask

  // called between edges; asserts reset, checks the immediate clear, releases
  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int k = 0; k < hold; k++) cyc(btn_raw);
    rst_n = 1'b1;
    prev_lvl0 = 1'b0;
  endtask

  task automatic mark();
    edge_idx = 0;
    pe0.delete();
    pe1.delete();
    fall0 = -1;
  endtask

  initial begin
    int exp4[4];
    int len;
    bit lvl;
    exp4[0] = 18; exp4[1] = 82; exp4[2] = 98; exp4[3] = 114;
    tick = 0;
    prev_lvl0 = 1'b0;
    rst_n = 1'b0;
    btn_raw = 1'b0;
    model_reset();
    mark();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();                      // reset state
    rst_n = 1'b1;

    // 1. clean press
    run(1'b0, 4);
    mark();
    run(1'b1, 40);
    check_val("t1_npulse", pe0.size(), 1);
    check_val("t1_edge", (pe0.size() > 0) ? pe0[0] : -1, 18);
    check_val("t1_count", {24'd0, if0.press_count}, 1);
    run(1'b0, 30);

    // 2. bounce never accepted
    pulse_reset(2);
    mark();
    for (int r = 0; r < 4; r++) begin
      run(1'b1, 5);
      run(1'b0, 3);
    end
    run(1'b0, 10);
    check_val("t2_npulse", pe0.size(), 0);
    check_val("t2_count", {24'd0, if0.press_count}, 0);
    check_val("t2_busy", {31'd0, if0.busy}, 0);

    // 3. release bounce then clean release
    pulse_reset(2);
    mark();
    run(1'b1, 40);
    run(1'b0, 6);
    run(1'b1, 20);
    check_val("t3_level", {31'd0, if0.btn_level}, 1);
    mark();
    run(1'b0, 30);
    check_val("t3_fall", fall0, 18);
    check_val("t3_npulse", pe0.size(), 0);

    // 4. auto-repeat while held
    pulse_reset(2);
    mark();
    run(1'b1, 120);
    run(1'b0, 30);
    check_val("t4_npulse", pe1.size(), 4);
    for (int i = 0; i < 4; i++)
      check_val("t4_edge", (i < pe1.size()) ? pe1[i] : -1, exp4[i]);
    check_val("t4_count", {24'd0, if1.press_count}, 4);

    // 5. reset in the middle of a press
    pulse_reset(2);
    mark();
    run(1'b1, 10);
    check_val("t5_busy_pre", {31'd0, if0.busy}, 1);
    pulse_reset(3);
    mark();
    run(1'b1, 30);
    check_val("t5_npulse", pe0.size(), 1);
    check_val("t5_edge", (pe0.size() > 0) ? pe0[0] : -1, 18);
    run(1'b0, 25);

    // 6. press counter wrap
    pulse_reset(2);
    mark();
    for (int p = 0; p < 256; p++) begin
      run(1'b1, 20);
      run(1'b0, 20);
    end
    check_val("t6_npulse", pe0.size(), 256);
    check_val("t6_count", {24'd0, if0.press_count}, 0);

    // randomized runs of mixed lengths with occasional resets
    pulse_reset(2);
    lvl = 1'b0;
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 8);
      else len = $urandom_range(10, 110);
      lvl = ~lvl;
      if ($urandom_range(0, 40) == 0) begin
        btn_raw = lvl;
        pulse_reset($urandom_range(1, 3));
      end
      run(lvl, len);
    end
    run(1'b0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
